// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid buffer,
// flush with drop accounting, whole-CPU hold and input-side bubble insertion.
module pipe_stage_skid #(
    parameter int unsigned DATA_W         = 160,
    parameter bit          SKID_EN        = 1'b1,
    parameter bit          CLEAR_ON_EMPTY = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              hold,
    input  logic              bubble,
    output logic [1:0]        occupancy,
    output logic [15:0]       drop_cnt
);
    localparam int unsigned CNT_W = 16;

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [CNT_W:0]    drop_sum;
    logic              space;
    logic              in_fire;
    logic              out_fire;

    // Without the skid entry, a full stage can still accept when the main entry drains.
    assign space     = SKID_EN ? ~skid_valid_q : (~main_valid_q | out_ready);
    assign in_ready  = ~flush & ~hold & ~bubble & rst_n & space;
    assign out_valid = main_valid_q & ~hold;
    assign out_fire  = out_valid & out_ready & ~flush;
    assign in_fire   = in_valid & in_ready;
    assign out_data  = main_data_q;
    assign occupancy = 2'(main_valid_q) + 2'(skid_valid_q);
    assign drop_cnt  = drop_cnt_q;
    assign drop_sum  = (CNT_W+1)'(drop_cnt_q) + (CNT_W+1)'(occupancy);

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        drop_cnt_d   = drop_cnt_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            if (CLEAR_ON_EMPTY) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
            drop_cnt_d = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
        end else if (!hold) begin
            if (skid_valid_q) begin
                // Two entries held: input is blocked, a drain promotes the skid entry.
                if (out_fire) begin
                    main_data_d  = skid_data_q;
                    skid_valid_d = 1'b0;
                    if (CLEAR_ON_EMPTY) begin
                        skid_data_d = '0;
                    end
                end
            end else if (main_valid_q) begin
                if (in_fire && out_fire) begin
                    main_data_d = in_data;
                end else if (in_fire) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = in_data;
                end else if (out_fire) begin
                    main_valid_d = 1'b0;
                    if (CLEAR_ON_EMPTY) begin
                        main_data_d = '0;
                    end
                end
            end else if (in_fire) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            drop_cnt_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    if (SKID_EN) begin : g_skid
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                skid_valid_q <= 1'b0;
                skid_data_q  <= '0;
            end else begin
                skid_valid_q <= skid_valid_d;
                skid_data_q  <= skid_data_d;
            end
        end
    end else begin : g_no_skid
        assign skid_valid_q = 1'b0;
        assign skid_data_q  = '0;
    end

endmodule
